interrupt_arbiter: RTL and testbench
====================================

Name: interrupt_arbiter

Overview:
Upstream source of `interrupt_signal` for the interrupt controller.
- Synchronises N external interrupt lines and detects their rising edges.
- Latches each edge into a pending register and applies a software mask.
- Selects the highest-priority pending request.
- Issues a single-cycle `interrupt_signal` pulse with the ISR id/address, then holds off further requests until the controller reports ISR return.

Parameters:
- N_IRQ, 4: number of external interrupt lines (1..8).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (>=2).
- ADDR_W, 12: width of ISR address; matches the PC width.
- ISR_BASE, 12'hF00: address of ISR 0.
- VEC_STRIDE, 12'h010: address spacing between consecutive ISRs.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- irq_in  in  N_IRQ  raw asynchronous interrupt lines, rising-edge triggered.
- mask_wr  in  1  write strobe for the mask register.
- mask_wdata  in  N_IRQ  new mask value; 1 = masked.
- ISR_running  in  1  from the interrupt controller; high while the ISR executes.
- ret_ISR  in  1  from the interrupt controller; one-cycle ISR-return indication.
- interrupt_signal  out  1  one-cycle request pulse to the interrupt controller.
- isr_id  out  clog2(N_IRQ)  index of the granted line; held until the next grant.
- isr_addr  out  ADDR_W  ISR_BASE + isr_id*VEC_STRIDE; held with isr_id.
- irq_pending  out  N_IRQ  pending register, readable for debug/CSR.
- irq_mask  out  N_IRQ  current mask register.
- busy  out  1  high from grant until return cooldown ends.

Behaviour:
- Reset (nrst low, asynchronous):
  - Synchronisers and previous-value registers cleared.
  - irq_pending = 0, irq_mask = all ones (all masked).
  - isr_id = 0, isr_addr = ISR_BASE, interrupt_signal = 0, busy = 0, state = IDLE.
  - Reset mid-ISR discards everything; no pulse is emitted on reset release.
- Synchroniser/edge detect:
  - edge[i] = sync[i] & ~sync_prev[i].
  - Level-high inputs generate no further edges.
  - Glitches shorter than one clk period may be lost; this is accepted.
- Pending:
  - pending[i] is set on edge[i] regardless of mask.
  - pending[i] is cleared on the cycle line i is granted.
  - Set and clear of the same bit in one cycle: set wins, so the interrupt re-pends.
- Mask:
  - On mask_wr, irq_mask <= mask_wdata; the new value applies to arbitration from the next cycle.
  - Masked pending bits stay pending and fire once unmasked.
- Arbitration: eligible = pending & ~mask. The lowest index has the highest priority (fixed priority).
- States:
  - IDLE: busy = 0. If eligible != 0 and ISR_running = 0, go to FIRE and latch isr_id/isr_addr for the winner.
  - FIRE: interrupt_signal = 1 for exactly one cycle; clear pending[isr_id]; go to BUSY.
  - BUSY: wait for ret_ISR = 1, or ISR_running falling from 1 to 0, then go to COOL. New edges keep pending; nothing fires.
  - COOL: one idle cycle so the controller can restore save_PC; then go to IDLE.
- Latency: from the first clk edge sampling irq_in high (SYNC_STAGES = 2, unmasked, IDLE), interrupt_signal is high in the cycle after the 4th edge.
- Nesting:
  - None. At most one outstanding grant.
  - ret_ISR outside BUSY is ignored.
- isr_addr arithmetic is modulo 2^ADDR_W; wrap-around is permitted, not flagged.

Decomposition:
- Shared package interrupt_pkg holds:
  - state enum (IDLE, FIRE, BUSY, COOL);
  - ISR_BASE/VEC_STRIDE defaults;
  - the ISR address width constant shared with interrupt_controller.
- Natural sub-module: irq_sync_edge.
  - One instance per line, parameterised by SYNC_STAGES.
  - Outputs the edge pulse.

Test Plan:
- Reset release, write mask = 4'b0000, raise irq_in[2] -> interrupt_signal one pulse after the 4th edge, isr_id = 2, isr_addr = 12'hF20, pending[2] cleared.
- irq_in[3] and irq_in[1] rising in the same cycle -> grant id 1 first; after ret_ISR plus one COOL cycle, grant id 3 (isr_addr 12'hF30).
- Mask = 4'b0001, edge on irq_in[0] -> pending = 4'b0001, no pulse; write mask = 0 -> pulse with id 0 within 2 cycles.
- Edge on irq_in[1] while in BUSY -> no pulse until ret_ISR; then exactly one pulse id 1. A second edge arriving in the FIRE cycle of the same line re-pends it.
- Assert nrst low during BUSY with pending = 4'b0110 -> all outputs return to reset values immediately; no pulse after release until new edges occur.
- Hold irq_in[0] high for 20 cycles -> exactly one pulse; no re-trigger after ret_ISR.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt arbiter / controller pair.
package interrupt_pkg;

   localparam int ISR_ADDR_W = 12;
   localparam logic [ISR_ADDR_W-1:0] ISR_BASE_DEF = 12'hF00;
   localparam logic [ISR_ADDR_W-1:0] VEC_STRIDE_DEF = 12'h010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FIRE = 2'd1,
      ST_BUSY = 2'd2,
      ST_COOL = 2'd3
   } arb_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-stage synchroniser for one asynchronous interrupt line with rising-edge detect.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic nrst,
   input  logic irq,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // Shift the raw line through the synchroniser and remember the last synced value.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], irq};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/interrupt_arbiter.sv
// Edge-triggered, maskable, fixed-priority interrupt arbiter issuing one request
// pulse per grant and holding off until the controller reports ISR return.
module interrupt_arbiter
   import interrupt_pkg::*;
#(
   parameter int                N_IRQ       = 4,
   parameter int                SYNC_STAGES = 2,
   parameter int                ADDR_W      = ISR_ADDR_W,
   parameter logic [ADDR_W-1:0] ISR_BASE    = ADDR_W'(ISR_BASE_DEF),
   parameter logic [ADDR_W-1:0] VEC_STRIDE  = ADDR_W'(VEC_STRIDE_DEF),
   localparam int               ID_W        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [N_IRQ-1:0]  irq_in,
   input  logic              mask_wr,
   input  logic [N_IRQ-1:0]  mask_wdata,
   input  logic              ISR_running,
   input  logic              ret_ISR,
   output logic              interrupt_signal,
   output logic [ID_W-1:0]   isr_id,
   output logic [ADDR_W-1:0] isr_addr,
   output logic [N_IRQ-1:0]  irq_pending,
   output logic [N_IRQ-1:0]  irq_mask,
   output logic              busy
);

   logic [N_IRQ-1:0]  edge_s;
   logic [N_IRQ-1:0]  eligible_s;
   logic [N_IRQ-1:0]  clear_s;
   logic [N_IRQ-1:0]  pend_nxt_s;
   logic [ID_W-1:0]   winner_s;
   logic [ADDR_W-1:0] winner_addr_s;
   logic              isr_done_s;

   logic [N_IRQ-1:0]  pending_r;
   logic [N_IRQ-1:0]  mask_r;
   logic [ID_W-1:0]   isr_id_r;
   logic [ADDR_W-1:0] isr_addr_r;
   logic              sig_r;
   logic              busy_r;
   logic              run_prev_r;
   arb_state_t        state_r;

   for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk  (clk),
         .nrst (nrst),
         .irq  (irq_in[g]),
         .rise (edge_s[g])
      );
   end

   // Priority pick, vector address and next pending value (a new edge beats the grant clear).
   always_comb begin
      eligible_s = pending_r & ~mask_r;
      winner_s   = {ID_W{1'b0}};
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         winner_s = eligible_s[i] ? ID_W'(i) : winner_s;
      end
      winner_addr_s = ISR_BASE + ADDR_W'(winner_s) * VEC_STRIDE;
      clear_s       = (state_r == ST_FIRE) ? (N_IRQ'(1'b1) << isr_id_r) : {N_IRQ{1'b0}};
      pend_nxt_s    = (pending_r & ~clear_s) | edge_s;
      isr_done_s    = ret_ISR | (run_prev_r & ~ISR_running);
   end

   // Grant FSM with registered request pulse, vector and busy flag.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pending_r  <= {N_IRQ{1'b0}};
         mask_r     <= {N_IRQ{1'b1}};
         isr_id_r   <= {ID_W{1'b0}};
         isr_addr_r <= ISR_BASE;
         sig_r      <= 1'b0;
         busy_r     <= 1'b0;
         run_prev_r <= 1'b0;
         state_r    <= ST_IDLE;
      end else begin
         run_prev_r <= ISR_running;
         pending_r  <= pend_nxt_s;
         if (mask_wr) begin
            mask_r <= mask_wdata;
         end
         case (state_r)
            ST_IDLE: begin
               if ((|eligible_s) && !ISR_running) begin
                  isr_id_r   <= winner_s;
                  isr_addr_r <= winner_addr_s;
                  sig_r      <= 1'b1;
                  busy_r     <= 1'b1;
                  state_r    <= ST_FIRE;
               end
            end
            ST_FIRE: begin
               sig_r   <= 1'b0;
               state_r <= ST_BUSY;
            end
            ST_BUSY: begin
               if (isr_done_s) begin
                  state_r <= ST_COOL;
               end
            end
            // One quiet cycle lets the controller restore its saved PC.
            ST_COOL: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               sig_r   <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign interrupt_signal = sig_r;
   assign isr_id           = isr_id_r;
   assign isr_addr         = isr_addr_r;
   assign irq_pending      = pending_r;
   assign irq_mask         = mask_r;
   assign busy             = busy_r;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: vector table, directed corner sequences
// and a randomized run against a cycle-level behavioural model.
module tb_interrupt_arbiter;

   logic        clk = 1'b0;
   logic        nrst;
   logic [3:0]  irq_in;
   logic        mask_wr;
   logic [3:0]  mask_wdata;
   logic        ISR_running;
   logic        ret_ISR;
   logic        interrupt_signal;
   logic [1:0]  isr_id;
   logic [11:0] isr_addr;
   logic [3:0]  irq_pending;
   logic [3:0]  irq_mask;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   interrupt_arbiter dut (
      .clk              (clk),
      .nrst             (nrst),
      .irq_in           (irq_in),
      .mask_wr          (mask_wr),
      .mask_wdata       (mask_wdata),
      .ISR_running      (ISR_running),
      .ret_ISR          (ret_ISR),
      .interrupt_signal (interrupt_signal),
      .isr_id           (isr_id),
      .isr_addr         (isr_addr),
      .irq_pending      (irq_pending),
      .irq_mask         (irq_mask),
      .busy             (busy)
   );

   typedef struct {
      logic [3:0]  mask;
      logic [3:0]  irq;
      logic        fire;
      logic [1:0]  id;
      logic [11:0] addr;
      logic [3:0]  pend_after;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst        = 1'b0;
      irq_in      = 4'b0000;
      mask_wr     = 1'b0;
      mask_wdata  = 4'b0000;
      ISR_running = 1'b0;
      ret_ISR     = 1'b0;
      repeat (3) tick();
      nrst = 1'b1;
   endtask

   task automatic set_mask(input logic [3:0] v);
      mask_wr    = 1'b1;
      mask_wdata = v;
      tick();
      mask_wr    = 1'b0;
   endtask

   task automatic wait_pulse(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (interrupt_signal === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // From the pulse cycle: enter the wait phase, return the ISR, land in the cool-down cycle.
   task automatic irq_done();
      tick();
      ret_ISR = 1'b1;
      tick();
      ret_ISR = 1'b0;
   endtask

   // Behavioural model: history of line samples, pending bits, and a grant phase.
   localparam int PH_FREE = 0, PH_PULSE = 1, PH_WAIT = 2, PH_COOL = 3;
   logic [3:0]  m_hist [3];
   logic [3:0]  m_pend;
   logic [3:0]  m_mask;
   int          m_phase;
   int          m_id;
   logic [11:0] m_addr;
   logic        m_run_prev;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_hist[i] = 4'b0000;
      m_pend     = 4'b0000;
      m_mask     = 4'b1111;
      m_phase    = PH_FREE;
      m_id       = 0;
      m_addr     = 12'hF00;
      m_run_prev = 1'b0;
   endtask

   task automatic model_step();
      logic [3:0] rise;
      logic [3:0] elig;
      logic [3:0] new_pend;
      int         w;
      rise     = m_hist[1] & ~m_hist[2];
      new_pend = m_pend;
      if (m_phase == PH_PULSE) new_pend[m_id] = 1'b0;
      new_pend = new_pend | rise;
      case (m_phase)
         PH_FREE: begin
            elig = m_pend & ~m_mask;
            if (elig != 4'b0000 && !ISR_running) begin
               w = 0;
               while (!elig[w]) w++;
               m_id    = w;
               m_addr  = 12'((32'hF00 + 32'd16 * w) % 32'd4096);
               m_phase = PH_PULSE;
            end
         end
         PH_PULSE: m_phase = PH_WAIT;
         PH_WAIT:  if (ret_ISR || (m_run_prev && !ISR_running)) m_phase = PH_COOL;
         default:  m_phase = PH_FREE;
      endcase
      if (mask_wr) m_mask = mask_wdata;
      m_pend     = new_pend;
      m_run_prev = ISR_running;
      m_hist[2]  = m_hist[1];
      m_hist[1]  = m_hist[0];
      m_hist[0]  = irq_in;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int pulses;

      vecs[0] = '{4'b0000, 4'b0100, 1'b1, 2'd2, 12'hF20, 4'b0000};
      vecs[1] = '{4'b0000, 4'b1010, 1'b1, 2'd1, 12'hF10, 4'b1000};
      vecs[2] = '{4'b0000, 4'b1000, 1'b1, 2'd3, 12'hF30, 4'b0000};
      vecs[3] = '{4'b0001, 4'b0011, 1'b1, 2'd1, 12'hF10, 4'b0001};
      vecs[4] = '{4'b1110, 4'b1111, 1'b1, 2'd0, 12'hF00, 4'b1110};
      vecs[5] = '{4'b0110, 4'b0110, 1'b0, 2'd0, 12'hF00, 4'b0110};

      // Reset state
      do_reset();
      chk("rst_sig", 32'(interrupt_signal), 32'd0);
      chk("rst_id", 32'(isr_id), 32'd0);
      chk("rst_addr", 32'(isr_addr), 32'hF00);
      chk("rst_pend", 32'(irq_pending), 32'd0);
      chk("rst_mask", 32'(irq_mask), 32'hF);
      chk("rst_busy", 32'(busy), 32'd0);

      // Vector table: exact 4-edge latency, winner, address and pending afterwards
      foreach (vecs[v]) begin
         do_reset();
         set_mask(vecs[v].mask);
         irq_in = vecs[v].irq;
         wait_pulse(8, n);
         if (vecs[v].fire) begin
            chk("vec_latency", 32'(n), 32'd4);
            chk("vec_id", 32'(isr_id), 32'(vecs[v].id));
            chk("vec_addr", 32'(isr_addr), 32'(vecs[v].addr));
            tick();
            chk("vec_pend", 32'(irq_pending), 32'(vecs[v].pend_after));
            chk("vec_pulse_width", 32'(interrupt_signal), 32'd0);
            chk("vec_busy", 32'(busy), 32'd1);
         end else begin
            chk("vec_nofire", 32'(n), 32'hFFFF_FFFF);
            chk("vec_pend", 32'(irq_pending), 32'(vecs[v].pend_after));
         end
         irq_in = 4'b0000;
      end

      // Simultaneous edges: lower index first, next grant after return plus one cool cycle
      do_reset();
      set_mask(4'b0000);
      irq_in = 4'b1010;
      wait_pulse(8, n);
      chk("pair_first_id", 32'(isr_id), 32'd1);
      irq_done();
      chk("pair_cool_sig", 32'(interrupt_signal), 32'd0);
      chk("pair_cool_busy", 32'(busy), 32'd1);
      tick();
      chk("pair_idle_busy", 32'(busy), 32'd0);
      chk("pair_idle_sig", 32'(interrupt_signal), 32'd0);
      tick();
      chk("pair_second_sig", 32'(interrupt_signal), 32'd1);
      chk("pair_second_id", 32'(isr_id), 32'd3);
      chk("pair_second_addr", 32'(isr_addr), 32'hF30);
      irq_done();
      chk("pair_pend_clear", 32'(irq_pending), 32'd0);
      irq_in = 4'b0000;

      // Masked edge stays pending, fires within 2 cycles of unmasking
      do_reset();
      set_mask(4'b0001);
      irq_in = 4'b0001;
      pulses = 0;
      repeat (6) begin
         tick();
         pulses += int'(interrupt_signal);
      end
      chk("mask_no_pulse", 32'(pulses), 32'd0);
      chk("mask_pend", 32'(irq_pending), 32'd1);
      set_mask(4'b0000);
      wait_pulse(2, n);
      chk("unmask_fire", 32'(n > 0), 32'd1);
      chk("unmask_id", 32'(isr_id), 32'd0);
      irq_done();
      irq_in = 4'b0000;

      // Edge during BUSY waits for return; held-high line never re-triggers
      do_reset();
      set_mask(4'b0000);
      irq_in = 4'b0001;
      wait_pulse(8, n);
      chk("busy_first_id", 32'(isr_id), 32'd0);
      tick();
      irq_in = 4'b0011;
      pulses = 0;
      repeat (8) begin
         tick();
         pulses += int'(interrupt_signal);
      end
      chk("busy_no_pulse", 32'(pulses), 32'd0);
      chk("busy_pend", 32'(irq_pending), 32'b0010);
      chk("busy_flag", 32'(busy), 32'd1);
      ret_ISR = 1'b1;
      tick();
      ret_ISR = 1'b0;
      tick();
      tick();
      chk("busy_next_sig", 32'(interrupt_signal), 32'd1);
      chk("busy_next_id", 32'(isr_id), 32'd1);
      irq_done();
      pulses = 0;
      repeat (10) begin
         tick();
         pulses += int'(interrupt_signal);
      end
      chk("busy_single", 32'(pulses), 32'd0);

      // Second edge of line 1 lands in its own FIRE cycle and re-pends it
      irq_in = 4'b0000;
      repeat (4) tick();
      irq_in = 4'b0010;
      tick();
      irq_in = 4'b0000;
      tick();
      irq_in = 4'b0010;
      tick();
      tick();
      chk("repend_sig", 32'(interrupt_signal), 32'd1);
      chk("repend_id", 32'(isr_id), 32'd1);
      tick();
      chk("repend_pend", 32'(irq_pending), 32'b0010);
      ret_ISR = 1'b1;
      tick();
      ret_ISR = 1'b0;
      tick();
      tick();
      chk("repend_refire", 32'(interrupt_signal), 32'd1);
      chk("repend_refire_id", 32'(isr_id), 32'd1);
      irq_done();
      chk("repend_clear", 32'(irq_pending), 32'd0);
      irq_in = 4'b0000;

      // Asynchronous reset in BUSY with two lines still pending
      do_reset();
      set_mask(4'b0000);
      irq_in = 4'b0111;
      wait_pulse(8, n);
      chk("rbusy_id", 32'(isr_id), 32'd0);
      tick();
      chk("rbusy_pend", 32'(irq_pending), 32'b0110);
      chk("rbusy_busy", 32'(busy), 32'd1);
      irq_in = 4'b0000;
      #2;
      nrst = 1'b0;
      #1;
      chk("rbusy_sig", 32'(interrupt_signal), 32'd0);
      chk("rbusy_rst_id", 32'(isr_id), 32'd0);
      chk("rbusy_rst_addr", 32'(isr_addr), 32'hF00);
      chk("rbusy_rst_pend", 32'(irq_pending), 32'd0);
      chk("rbusy_rst_mask", 32'(irq_mask), 32'hF);
      chk("rbusy_rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      nrst = 1'b1;
      pulses = 0;
      repeat (10) begin
         tick();
         pulses += int'(interrupt_signal);
      end
      set_mask(4'b0000);
      repeat (8) begin
         tick();
         pulses += int'(interrupt_signal);
      end
      chk("rbusy_no_pulse", 32'(pulses), 32'd0);
      chk("rbusy_pend_after", 32'(irq_pending), 32'd0);

      // Level held high for 20+ cycles gives exactly one grant
      do_reset();
      set_mask(4'b0000);
      irq_in = 4'b0001;
      wait_pulse(8, n);
      chk("level_latency", 32'(n), 32'd4);
      pulses = 1;
      irq_done();
      repeat (20) begin
         tick();
         pulses += int'(interrupt_signal);
      end
      chk("level_single", 32'(pulses), 32'd1);
      irq_in = 4'b0000;

      // Randomized run against the behavioural model
      nrst        = 1'b0;
      irq_in      = 4'b0000;
      mask_wr     = 1'b0;
      mask_wdata  = 4'b0000;
      ISR_running = 1'b0;
      ret_ISR     = 1'b0;
      model_reset();
      repeat (2) tick();
      nrst = 1'b1;
      for (int c = 0; c < 600; c++) begin
         irq_in     = irq_in ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         mask_wr    = ($urandom_range(0, 11) == 0);
         mask_wdata = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         ret_ISR    = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 4) == 0) ISR_running = ~ISR_running;
         @(posedge clk);
         model_step();
         #1;
         chk("rnd_sig", 32'(interrupt_signal), 32'(m_phase == PH_PULSE));
         chk("rnd_busy", 32'(busy), 32'(m_phase != PH_FREE));
         chk("rnd_id", 32'(isr_id), 32'(m_id));
         chk("rnd_addr", 32'(isr_addr), 32'(m_addr));
         chk("rnd_pend", 32'(irq_pending), 32'(m_pend));
         chk("rnd_mask", 32'(irq_mask), 32'(m_mask));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
